mem_arbiter: RTL

- Shares the single-port 32-bit image memory between two requesters: the host transfer controller (port h_*, PC upload/download/clear) and the image-processing accelerator (port a_*).
- Sits between both requesters and the memory. It issues at most one access per cycle and routes read-return validity back to the requester that issued the read.
- Supports locked bursts with a bounded lock length, so neither side can starve the other.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_arb_pkg.sv
// Types and constants shared by the image-memory arbiter and the requesters that sit on it.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB    = 2'b00,
    LOCK_H = 2'b01,
    LOCK_A = 2'b10
  } owner_t;

  localparam logic REQ_H = 1'b0;
  localparam logic REQ_A = 1'b1;

  localparam int unsigned DEFAULT_ADDR_SIZE = 16;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port image memory: host transfer port (h_*) and
// accelerator port (a_*), with bounded locked bursts and per-requester read-return routing.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEMORY_ADDR_SIZE = DEFAULT_ADDR_SIZE,
  parameter int unsigned LOCK_MAX         = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        h_req,
  input  logic                        h_lock,
  input  logic                        h_we,
  input  logic [MEMORY_ADDR_SIZE-1:0] h_addr,
  input  logic [31:0]                 h_dw,
  output logic                        h_gnt,
  output logic                        h_rvalid,
  input  logic                        a_req,
  input  logic                        a_lock,
  input  logic                        a_we,
  input  logic [MEMORY_ADDR_SIZE-1:0] a_addr,
  input  logic [31:0]                 a_dw,
  output logic                        a_gnt,
  output logic                        a_rvalid,
  output logic [31:0]                 rd_data,
  output logic [1:0]                  owner,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [MEMORY_ADDR_SIZE-1:0] mem_addr,
  output logic [31:0]                 mem_dw,
  input  logic [31:0]                 mem_dr
);

  localparam int unsigned      CNT_W   = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  owner_t           r_state, w_state_nxt, w_arb_state;
  logic             r_last, w_last_nxt;
  logic [CNT_W-1:0] r_lock_cnt, w_cnt_nxt, w_cnt_inc, w_arb_cnt;
  logic             r_h_rvalid, r_a_rvalid;
  logic             w_arb_h, w_arb_a;
  logic             w_h_gnt, w_a_gnt;

  always_comb begin
    w_h_gnt     = 1'b0;
    w_a_gnt     = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_lock_cnt;

    // Open arbitration: a lone requester wins, a tie goes to whoever was not served last.
    w_arb_h     = h_req && (!a_req || (r_last == REQ_A));
    w_arb_a     = a_req && !w_arb_h;
    w_arb_state = ARB;
    if (w_arb_h && h_lock) begin
      w_arb_state = LOCK_H;
    end else if (w_arb_a && a_lock) begin
      w_arb_state = LOCK_A;
    end
    w_arb_cnt = (w_arb_state == ARB) ? '0 : CNT_ONE;
    w_cnt_inc = (r_lock_cnt == CNT_MAX) ? r_lock_cnt : r_lock_cnt + CNT_ONE;

    // In a lock state the owner's own unlocked access still wins; it closes the lock.
    unique case (r_state)
      LOCK_H: begin
        if (a_req && (r_lock_cnt == CNT_MAX)) begin
          w_a_gnt   = 1'b1;
          w_cnt_nxt = '0;
        end else if (h_req) begin
          w_h_gnt = 1'b1;
          if (h_lock) begin
            if (a_req) w_cnt_nxt = w_cnt_inc;
          end else begin
            w_state_nxt = ARB;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_h_gnt     = w_arb_h;
          w_a_gnt     = w_arb_a;
          w_state_nxt = w_arb_state;
          w_cnt_nxt   = w_arb_cnt;
        end
      end
      LOCK_A: begin
        if (h_req && (r_lock_cnt == CNT_MAX)) begin
          w_h_gnt   = 1'b1;
          w_cnt_nxt = '0;
        end else if (a_req) begin
          w_a_gnt = 1'b1;
          if (a_lock) begin
            if (h_req) w_cnt_nxt = w_cnt_inc;
          end else begin
            w_state_nxt = ARB;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_h_gnt     = w_arb_h;
          w_a_gnt     = w_arb_a;
          w_state_nxt = w_arb_state;
          w_cnt_nxt   = w_arb_cnt;
        end
      end
      default: begin
        w_h_gnt     = w_arb_h;
        w_a_gnt     = w_arb_a;
        w_state_nxt = w_arb_state;
        w_cnt_nxt   = w_arb_cnt;
      end
    endcase

    if (reset) begin
      w_h_gnt = 1'b0;
      w_a_gnt = 1'b0;
    end

    w_last_nxt = r_last;
    if (w_h_gnt) begin
      w_last_nxt = REQ_H;
    end else if (w_a_gnt) begin
      w_last_nxt = REQ_A;
    end
  end

  always_comb begin
    mem_en   = w_h_gnt || w_a_gnt;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_dw   = '0;
    if (w_h_gnt) begin
      mem_we   = h_we;
      mem_addr = h_addr;
      mem_dw   = h_dw;
    end else if (w_a_gnt) begin
      mem_we   = a_we;
      mem_addr = a_addr;
      mem_dw   = a_dw;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ARB;
      r_last     <= REQ_A;
      r_lock_cnt <= '0;
      r_h_rvalid <= 1'b0;
      r_a_rvalid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_lock_cnt <= w_cnt_nxt;
      r_h_rvalid <= w_h_gnt && !h_we;
      r_a_rvalid <= w_a_gnt && !a_we;
    end
  end

  assign h_gnt    = w_h_gnt;
  assign a_gnt    = w_a_gnt;
  assign h_rvalid = r_h_rvalid;
  assign a_rvalid = r_a_rvalid;
  assign rd_data  = mem_dr;
  assign owner    = r_state;

endmodule
